codec_i2c_arbiter: RTL and testbench

- Shares the single codec I2C controller channel (wr/rd strobe, addr, data, busy, clear, missed_ack) between two requesters.
  - Requester 0: the AXI register path.
  - Requester 1: the hardware codec config sequencer (volume/mute updates).
- Round-robin arbitration; one transaction in flight; per-transaction timeout; single tagged response bus.
- Lives in the AXI clock domain, between the register unit and the controller unit.

---
 rtl/codec_i2c_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_codec_i2c_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_i2c_arbiter.sv
// Round-robin arbiter sharing the codec I2C controller between the AXI register path (0)
// and the codec config sequencer (1). Optional statistics counters: CODEC_I2C_ARB_STATS_EN.
module codec_i2c_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int TO_CNT_WIDTH   = 17
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic                  codec_init_done,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_rd,
    input  logic [DATA_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wr_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_rd,
    input  logic [DATA_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wr_data,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_status,
    output logic                  codec_i2c_data_wr,
    output logic                  codec_i2c_data_rd,
    output logic [DATA_WIDTH-1:0] codec_i2c_addr,
    output logic [DATA_WIDTH-1:0] codec_i2c_wr_data,
    input  logic                  clear_codec_i2c_data_wr,
    input  logic                  clear_codec_i2c_data_rd,
    input  logic                  controller_busy,
    input  logic                  missed_ack,
    input  logic [DATA_WIDTH-1:0] codec_i2c_rd_data,
    input  logic                  update_codec_i2c_rd_data,
    output logic [15:0]           stat_done0,
    output logic [15:0]           stat_done1,
    output logic [15:0]           stat_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_NACK    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    // Compare against the pre-increment value so the strobe drops as the count reaches TIMEOUT_CYCLES-1.
    localparam logic [TO_CNT_WIDTH-1:0] TO_LAST = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 2);

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    rr_last_r;
    logic                    id_r;
    logic                    is_rd_r;
    logic [TO_CNT_WIDTH-1:0] to_cnt_r;
    logic                    nack_r;
    logic                    rd_seen_r;
    logic [DATA_WIDTH-1:0]   rd_data_r;

    logic                    grant_s;
    logic                    grant_id_s;
    logic                    clear_match_s;
    logic                    timeout_s;
    logic                    done_s;
    logic                    go_resp_s;
    logic                    nack_now_s;
    logic                    rd_seen_now_s;
    logic [DATA_WIDTH-1:0]   rd_data_now_s;
    logic [1:0]              rsp_status_s;
    logic [DATA_WIDTH-1:0]   rsp_data_s;

    // Next-state, grant selection and response field computation.
    always_comb begin
        state_next_s  = state_r;
        grant_s       = 1'b0;
        timeout_s     = 1'b0;
        done_s        = 1'b0;
        nack_now_s    = nack_r | missed_ack;
        rd_seen_now_s = rd_seen_r | update_codec_i2c_rd_data;
        rd_data_now_s = update_codec_i2c_rd_data ? codec_i2c_rd_data : rd_data_r;
        clear_match_s = is_rd_r ? clear_codec_i2c_data_rd : clear_codec_i2c_data_wr;
        if (req0_valid && req1_valid) begin
            grant_id_s = ~rr_last_r;
        end else begin
            grant_id_s = req1_valid;
        end
        case (state_r)
            S_IDLE: begin
                if (codec_init_done && (req0_valid || req1_valid)) begin
                    grant_s      = 1'b1;
                    state_next_s = S_ISSUE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                timeout_s = (to_cnt_r == TO_LAST);
                if (timeout_s) begin
                    state_next_s = S_RESP;
                end else if (clear_match_s) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_ISSUE;
                end
            end
            S_WAIT: begin
                timeout_s = (to_cnt_r == TO_LAST);
                done_s    = !controller_busy && (!is_rd_r || rd_seen_now_s);
                if (timeout_s || done_s) begin
                    state_next_s = S_RESP;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_RESP: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
        go_resp_s  = (state_next_s == S_RESP) && (state_r != S_RESP);
        req0_ready = grant_s && !grant_id_s;
        req1_ready = grant_s && grant_id_s;
        if (timeout_s) begin
            rsp_status_s = ST_TIMEOUT;
        end else if (nack_now_s) begin
            rsp_status_s = ST_NACK;
        end else begin
            rsp_status_s = ST_OK;
        end
        if (is_rd_r && !timeout_s) begin
            rsp_data_s = rd_data_now_s;
        end else begin
            rsp_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Transaction latch, strobes, timeout counter, sticky flags and response registers.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            rr_last_r         <= 1'b1;
            id_r              <= 1'b0;
            is_rd_r           <= 1'b0;
            to_cnt_r          <= {TO_CNT_WIDTH{1'b0}};
            nack_r            <= 1'b0;
            rd_seen_r         <= 1'b0;
            rd_data_r         <= {DATA_WIDTH{1'b0}};
            codec_i2c_data_wr <= 1'b0;
            codec_i2c_data_rd <= 1'b0;
            codec_i2c_addr    <= {DATA_WIDTH{1'b0}};
            codec_i2c_wr_data <= {DATA_WIDTH{1'b0}};
            rsp_valid         <= 1'b0;
            rsp_id            <= 1'b0;
            rsp_status        <= 2'd0;
            rsp_data          <= {DATA_WIDTH{1'b0}};
        end else begin
            rsp_valid  <= go_resp_s;
            rsp_id     <= go_resp_s ? id_r : 1'b0;
            rsp_status <= go_resp_s ? rsp_status_s : 2'd0;
            rsp_data   <= go_resp_s ? rsp_data_s : {DATA_WIDTH{1'b0}};
            case (state_r)
                S_IDLE: begin
                    if (grant_s) begin
                        is_rd_r           <= grant_id_s ? req1_rd : req0_rd;
                        codec_i2c_data_rd <= grant_id_s ? req1_rd : req0_rd;
                        codec_i2c_data_wr <= grant_id_s ? !req1_rd : !req0_rd;
                        codec_i2c_addr    <= grant_id_s ? req1_addr : req0_addr;
                        codec_i2c_wr_data <= grant_id_s ? req1_wr_data : req0_wr_data;
                        id_r              <= grant_id_s;
                        rr_last_r         <= grant_id_s;
                        to_cnt_r          <= {TO_CNT_WIDTH{1'b0}};
                        nack_r            <= 1'b0;
                        rd_seen_r         <= 1'b0;
                        rd_data_r         <= {DATA_WIDTH{1'b0}};
                    end
                end
                S_ISSUE, S_WAIT: begin
                    to_cnt_r  <= to_cnt_r + TO_CNT_WIDTH'(1);
                    nack_r    <= nack_now_s;
                    rd_seen_r <= rd_seen_now_s;
                    rd_data_r <= rd_data_now_s;
                    if (timeout_s || ((state_r == S_ISSUE) && clear_match_s)) begin
                        codec_i2c_data_wr <= 1'b0;
                        codec_i2c_data_rd <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CODEC_I2C_ARB_STATS_EN
    logic [15:0] done0_r;
    logic [15:0] done1_r;
    logic [15:0] err_r;

    // Saturating completion and error counters, sampled on the RESP cycle.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            done0_r <= 16'd0;
            done1_r <= 16'd0;
            err_r   <= 16'd0;
        end else if (rsp_valid) begin
            if ((rsp_status == ST_OK) && !rsp_id && (done0_r != 16'hFFFF)) begin
                done0_r <= done0_r + 16'd1;
            end
            if ((rsp_status == ST_OK) && rsp_id && (done1_r != 16'hFFFF)) begin
                done1_r <= done1_r + 16'd1;
            end
            if ((rsp_status != ST_OK) && (err_r != 16'hFFFF)) begin
                err_r <= err_r + 16'd1;
            end
        end
    end

    assign stat_done0 = done0_r;
    assign stat_done1 = done1_r;
    assign stat_err   = err_r;
`else
    assign stat_done0 = 16'd0;
    assign stat_done1 = 16'd0;
    assign stat_err   = 16'd0;
`endif

endmodule

// File: tb/tb_codec_i2c_arbiter.sv
// Directed self-checking bench for codec_i2c_arbiter (TIMEOUT_CYCLES=16); a scripted
// controller responds per slot and each scenario task checks its own hand-computed results.
module tb_codec_i2c_arbiter;
    localparam int DW = 32;

    logic          axi_clk = 1'b0;
    logic          axi_reset = 1'b1;
    logic          codec_init_done = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic          req0_rd = 1'b0, req1_rd = 1'b0;
    logic [DW-1:0] req0_addr = '0, req0_wr_data = '0, req1_addr = '0, req1_wr_data = '0;
    logic          rsp_valid, rsp_id;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_status;
    logic          codec_i2c_data_wr, codec_i2c_data_rd;
    logic [DW-1:0] codec_i2c_addr, codec_i2c_wr_data;
    logic          clear_codec_i2c_data_wr = 1'b0, clear_codec_i2c_data_rd = 1'b0;
    logic          controller_busy = 1'b0, missed_ack = 1'b0;
    logic [DW-1:0] codec_i2c_rd_data = '0;
    logic          update_codec_i2c_rd_data = 1'b0;
    logic [15:0]   stat_done0, stat_done1, stat_err;

    int checks = 0;
    int errors = 0;
    int dual_cnt = 0;

    int            o_rise, o_fall, o_rsp_slot, o_rsp_cnt, o_wr_hi, o_rd_hi;
    bit            o_ready_ok;
    logic          o_rsp_id;
    logic [1:0]    o_rsp_status;
    logic [DW-1:0] o_rsp_data, o_addr, o_wdata;

    codec_i2c_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(16), .TO_CNT_WIDTH(5)) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .codec_init_done(codec_init_done),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd),
        .req0_addr(req0_addr), .req0_wr_data(req0_wr_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd),
        .req1_addr(req1_addr), .req1_wr_data(req1_wr_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .codec_i2c_data_wr(codec_i2c_data_wr), .codec_i2c_data_rd(codec_i2c_data_rd),
        .codec_i2c_addr(codec_i2c_addr), .codec_i2c_wr_data(codec_i2c_wr_data),
        .clear_codec_i2c_data_wr(clear_codec_i2c_data_wr),
        .clear_codec_i2c_data_rd(clear_codec_i2c_data_rd),
        .controller_busy(controller_busy), .missed_ack(missed_ack),
        .codec_i2c_rd_data(codec_i2c_rd_data),
        .update_codec_i2c_rd_data(update_codec_i2c_rd_data),
        .stat_done0(stat_done0), .stat_done1(stat_done1), .stat_err(stat_err)
    );

    always #5 axi_clk = ~axi_clk;

    always @(negedge axi_clk) begin
        if (codec_i2c_data_wr && codec_i2c_data_rd) dual_cnt++;
    end

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    // Slot 0 presents the request; controller events are scheduled by slot index (-1 = never).
    task automatic do_txn(input bit id, input bit rd, input logic [DW-1:0] addr,
                          input logic [DW-1:0] wdata, input int clr_at, input bit clr_both,
                          input int busy_low_at, input int upd_at, input logic [DW-1:0] upd_val,
                          input int nack_at, input int max_slots);
        o_rise = -1; o_fall = -1; o_rsp_slot = -1; o_rsp_cnt = 0; o_wr_hi = 0; o_rd_hi = 0;
        o_ready_ok = 1'b0; o_rsp_id = 1'b0; o_rsp_status = 2'd0; o_rsp_data = '0;
        o_addr = '0; o_wdata = '0;
        for (int k = 0; k < max_slots; k++) begin
            if (k == 0) begin
                if (id) begin
                    req1_valid = 1'b1; req1_rd = rd; req1_addr = addr; req1_wr_data = wdata;
                end else begin
                    req0_valid = 1'b1; req0_rd = rd; req0_addr = addr; req0_wr_data = wdata;
                end
            end else begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            clear_codec_i2c_data_wr  = (k == clr_at) && (clr_both || !rd);
            clear_codec_i2c_data_rd  = (k == clr_at) && (clr_both || rd);
            controller_busy          = (clr_at >= 0) && (k >= clr_at) && (k < busy_low_at);
            update_codec_i2c_rd_data = (k == upd_at);
            codec_i2c_rd_data        = (k == upd_at) ? upd_val : 32'hDEAD_BEEF;
            missed_ack               = (k == nack_at);
            #1;
            if (k == 0) o_ready_ok = id ? (req1_ready && !req0_ready) : (req0_ready && !req1_ready);
            if (k == 1) begin
                o_addr  = codec_i2c_addr;
                o_wdata = codec_i2c_wr_data;
            end
            if (codec_i2c_data_wr) o_wr_hi++;
            if (codec_i2c_data_rd) o_rd_hi++;
            if ((codec_i2c_data_wr || codec_i2c_data_rd) && o_rise < 0) o_rise = k;
            if (!(codec_i2c_data_wr || codec_i2c_data_rd) && o_rise >= 0 && o_fall < 0) o_fall = k;
            if (rsp_valid) begin
                o_rsp_cnt++;
                if (o_rsp_slot < 0) begin
                    o_rsp_slot = k; o_rsp_id = rsp_id; o_rsp_status = rsp_status; o_rsp_data = rsp_data;
                end
            end
            tick();
        end
        clear_codec_i2c_data_wr = 1'b0; clear_codec_i2c_data_rd = 1'b0;
        controller_busy = 1'b0; update_codec_i2c_rd_data = 1'b0; missed_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_status, codec_i2c_data_wr, codec_i2c_data_rd} !== 6'd0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 0", {rsp_valid, rsp_id, rsp_status, codec_i2c_data_wr, codec_i2c_data_rd});
        end
        checks++;
        if ({rsp_data, codec_i2c_addr, codec_i2c_wr_data} !== 96'd0) begin
            errors++; $display("FAIL reset_data: got %h required 0", {rsp_data, codec_i2c_addr, codec_i2c_wr_data});
        end
        checks++;
        if ({stat_done0, stat_done1, stat_err} !== 48'd0) begin
            errors++; $display("FAIL reset_stats: got %h required 0", {stat_done0, stat_done1, stat_err});
        end
        axi_reset = 1'b0;
        codec_init_done = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        do_txn(1'b0, 1'b0, 32'h1A, 32'h5F, 3, 1'b0, 13, -1, 32'h0, -1, 18);
        checks++;
        if (!o_ready_ok) begin errors++; $display("FAIL wr_ready: got 0 required 1"); end
        checks++;
        if ({o_addr, o_wdata} !== {32'h1A, 32'h5F}) begin
            errors++; $display("FAIL wr_latch: got %h/%h required 1a/5f", o_addr, o_wdata);
        end
        checks++;
        if ({o_rise, o_fall} !== {32'sd1, 32'sd4}) begin
            errors++; $display("FAIL wr_strobe: got rise %0d fall %0d required 1/4", o_rise, o_fall);
        end
        checks++;
        if (o_rsp_slot !== 14 || o_rsp_cnt !== 1) begin
            errors++; $display("FAIL wr_rsp_timing: got slot %0d count %0d required 14/1", o_rsp_slot, o_rsp_cnt);
        end
        checks++;
        if ({o_rsp_id, o_rsp_status, o_rsp_data} !== {1'b0, 2'd0, 32'h0}) begin
            errors++; $display("FAIL wr_rsp: got id %0d st %0d data %h required 0/0/0", o_rsp_id, o_rsp_status, o_rsp_data);
        end
        checks++;
        if (o_rd_hi !== 0) begin errors++; $display("FAIL wr_no_rd: got %0d required 0", o_rd_hi); end
    endtask

    task automatic test_read();
        do_txn(1'b1, 1'b1, 32'h07, 32'h0, 2, 1'b1, 8, 6, 32'h0000_00A3, -1, 12);
        checks++;
        if (!o_ready_ok) begin errors++; $display("FAIL rd_ready: got 0 required 1"); end
        checks++;
        if (o_wr_hi !== 0 || o_addr !== 32'h07) begin
            errors++; $display("FAIL rd_strobe: got wr_hi %0d addr %h required 0/07", o_wr_hi, o_addr);
        end
        checks++;
        if ({o_rise, o_fall} !== {32'sd1, 32'sd3}) begin
            errors++; $display("FAIL rd_strobe_len: got rise %0d fall %0d required 1/3", o_rise, o_fall);
        end
        checks++;
        if (o_rsp_slot !== 9 || {o_rsp_id, o_rsp_status, o_rsp_data} !== {1'b1, 2'd0, 32'h0000_00A3}) begin
            errors++; $display("FAIL rd_rsp: got slot %0d id %0d st %0d data %h required 9/1/0/a3", o_rsp_slot, o_rsp_id, o_rsp_status, o_rsp_data);
        end
    endtask

    task automatic test_contention();
        int g_cnt = 0;
        int dbl = 0;
        int rsp_n = 0;
        int dual0 = dual_cnt;
        logic [3:0] order = 4'd0;
        bit prev0 = 1'b0, prev1 = 1'b0;
        req0_rd = 1'b0; req0_addr = 32'h10; req0_wr_data = 32'h01;
        req1_rd = 1'b0; req1_addr = 32'h20; req1_wr_data = 32'h02;
        for (int k = 0; k < 30; k++) begin
            req0_valid = (g_cnt < 4);
            req1_valid = (g_cnt < 4);
            clear_codec_i2c_data_wr = codec_i2c_data_wr;
            controller_busy = 1'b0;
            #1;
            if ((req0_ready && prev0) || (req1_ready && prev1) || (req0_ready && req1_ready)) dbl++;
            prev0 = req0_ready;
            prev1 = req1_ready;
            if ((req0_ready || req1_ready) && g_cnt < 4) begin
                order[g_cnt] = req1_ready;
                g_cnt++;
            end
            if (rsp_valid) rsp_n++;
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; clear_codec_i2c_data_wr = 1'b0;
        checks++;
        if (g_cnt !== 4 || order !== 4'b1010) begin
            errors++; $display("FAIL cont_order: got %0d grants order(bit i=grant i) %b required 4/1010", g_cnt, order);
        end
        checks++;
        if (dbl !== 0) begin errors++; $display("FAIL cont_ready_pulse: got %0d bad pulses required 0", dbl); end
        checks++;
        if (rsp_n !== 4) begin errors++; $display("FAIL cont_rsp_count: got %0d required 4", rsp_n); end
        checks++;
        if (dual_cnt - dual0 !== 0) begin errors++; $display("FAIL cont_dual_strobe: got %0d required 0", dual_cnt - dual0); end
    endtask

    task automatic test_nack();
        do_txn(1'b0, 1'b0, 32'h2B, 32'h11, 1, 1'b1, 5, -1, 32'h0, 3, 10);
        checks++;
        if ({o_rise, o_fall} !== {32'sd1, 32'sd2}) begin
            errors++; $display("FAIL nack_same_cycle_clear: got rise %0d fall %0d required 1/2", o_rise, o_fall);
        end
        checks++;
        if (o_rsp_slot !== 6 || {o_rsp_id, o_rsp_status, o_rsp_data} !== {1'b0, 2'd1, 32'h0}) begin
            errors++; $display("FAIL nack_rsp: got slot %0d id %0d st %0d data %h required 6/0/1/0", o_rsp_slot, o_rsp_id, o_rsp_status, o_rsp_data);
        end
`ifdef CODEC_I2C_ARB_STATS_EN
        checks++;
        if ({stat_done0, stat_done1, stat_err} !== {16'd3, 16'd3, 16'd1}) begin
            errors++; $display("FAIL nack_stats: got %0d/%0d/%0d required 3/3/1", stat_done0, stat_done1, stat_err);
        end
`else
        checks++;
        if ({stat_done0, stat_done1, stat_err} !== 48'd0) begin
            errors++; $display("FAIL nack_stats_off: got %h required 0", {stat_done0, stat_done1, stat_err});
        end
`endif
    endtask

    task automatic test_timeout();
        do_txn(1'b1, 1'b1, 32'h09, 32'h0, -1, 1'b0, 0, 5, 32'h55, 4, 20);
        checks++;
        if (o_rise !== 1 || o_fall - o_rise !== 15 || o_rd_hi !== 15) begin
            errors++; $display("FAIL to_strobe: got rise %0d fall %0d hi %0d required 1/16/15", o_rise, o_fall, o_rd_hi);
        end
        checks++;
        if (o_rsp_slot !== 16 || {o_rsp_id, o_rsp_status, o_rsp_data} !== {1'b1, 2'd2, 32'h0}) begin
            errors++; $display("FAIL to_rsp: got slot %0d id %0d st %0d data %h required 16/1/2/0", o_rsp_slot, o_rsp_id, o_rsp_status, o_rsp_data);
        end
        do_txn(1'b0, 1'b0, 32'h40, 32'h41, 1, 1'b0, 0, -1, 32'h0, -1, 8);
        checks++;
        if (!o_ready_ok || o_rsp_slot !== 3 || o_rsp_status !== 2'd0) begin
            errors++; $display("FAIL to_next_grant: got ready %0d slot %0d st %0d required 1/3/0", o_ready_ok, o_rsp_slot, o_rsp_status);
        end
    endtask

    task automatic test_gating_reset();
        int rdy = 0;
        int rsp_n = 0;
        codec_init_done = 1'b0;
        req0_valid = 1'b1; req0_rd = 1'b0; req0_addr = 32'h33; req0_wr_data = 32'h44;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (req0_ready || req1_ready) rdy++;
            tick();
        end
        checks++;
        if (rdy !== 0) begin errors++; $display("FAIL gate_no_ready: got %0d required 0", rdy); end
        codec_init_done = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL gate_grant: got %b required 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++;
        if (codec_i2c_data_wr !== 1'b1) begin errors++; $display("FAIL gate_issue: got %b required 1", codec_i2c_data_wr); end
        axi_reset = 1'b1;
        tick();
        #1;
        checks++;
        if ({codec_i2c_data_wr, codec_i2c_data_rd, rsp_valid, codec_i2c_addr, codec_i2c_wr_data} !== 67'd0) begin
            errors++; $display("FAIL rst_mid_txn: got %h required 0", {codec_i2c_data_wr, codec_i2c_data_rd, rsp_valid, codec_i2c_addr, codec_i2c_wr_data});
        end
        axi_reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (rsp_valid) rsp_n++;
            tick();
        end
        checks++;
        if (rsp_n !== 0) begin errors++; $display("FAIL rst_no_rsp: got %0d required 0", rsp_n); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_nack();
        test_timeout();
        test_gating_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
